// File: rtl/alarm_tone_if.sv
// Alarm tone generator signal bundle: the enable from the speaker PIO and
// the speaker-side outputs of the melody generator.
interface alarm_tone_if;
  logic       alarm_en;
  logic       spk_out;
  logic       playing;
  logic [2:0] note_idx;

  // Controller side: drives the enable, observes the speaker outputs.
  modport master (
    output alarm_en,
    input  spk_out,
    input  playing,
    input  note_idx
  );

  // Generator side: consumes the enable, drives the speaker outputs.
  modport slave (
    input  alarm_en,
    output spk_out,
    output playing,
    output note_idx
  );
endinterface

// File: rtl/alarm_tone_gen.sv
// Alarm melody generator: while alarm_en is high, plays C5..C6 ascending as
// square waves on spk_out, each note followed by a silent gap and each pass
// followed by a pause. Dropping alarm_en returns to idle; re-enabling always
// restarts from note 0.
module alarm_tone_gen #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned NOTE_CYCLES  = 12_500_000,
  parameter int unsigned GAP_CYCLES   = 1_250_000,
  parameter int unsigned PAUSE_CYCLES = 25_000_000
) (
  input logic         clk_clk,
  input logic         reset_reset_n,
  alarm_tone_if.slave bus
);

  // Half-period in clock cycles for a tone of frequency f.
  function automatic int unsigned hp_of(input int unsigned f);
    return CLK_HZ / (2 * f);
  endfunction

  // C5 is the lowest note, so it has the longest half-period.
  localparam int unsigned HP_MAX   = hp_of(523);
  localparam int unsigned HW       = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;
  localparam int unsigned SLOT_MAX = (NOTE_CYCLES > PAUSE_CYCLES) ? NOTE_CYCLES : PAUSE_CYCLES;
  localparam int unsigned SW       = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;

  localparam logic [SW-1:0] TONE_LAST  = SW'(NOTE_CYCLES - GAP_CYCLES - 1);
  localparam logic [SW-1:0] NOTE_LAST  = SW'(NOTE_CYCLES - 1);
  localparam logic [SW-1:0] PAUSE_LAST = SW'(PAUSE_CYCLES - 1);

  // Terminal value of half_cnt for each note (HP[i]-1).
  function automatic logic [HW-1:0] hp_last(input logic [2:0] idx);
    logic [HW-1:0] r;
    case (idx)
      3'd0:    r = HW'(hp_of(523)  - 1);
      3'd1:    r = HW'(hp_of(587)  - 1);
      3'd2:    r = HW'(hp_of(659)  - 1);
      3'd3:    r = HW'(hp_of(698)  - 1);
      3'd4:    r = HW'(hp_of(784)  - 1);
      3'd5:    r = HW'(hp_of(880)  - 1);
      3'd6:    r = HW'(hp_of(988)  - 1);
      default: r = HW'(hp_of(1047) - 1);
    endcase
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_TONE,
    S_GAP,
    S_PAUSE
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] half_cnt, half_nxt;
  logic [SW-1:0] slot_cnt, slot_nxt;
  logic          spk_q, spk_nxt;
  logic [2:0]    idx_q, idx_nxt;
  logic          playing_q, playing_nxt;

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= S_IDLE;
    else                state <= state_nxt;
  end

  // Next state, counters and outputs; disable overrides every transition.
  always_comb begin
    state_nxt = state;
    half_nxt  = half_cnt;
    slot_nxt  = slot_cnt;
    spk_nxt   = spk_q;
    idx_nxt   = idx_q;

    if (!bus.alarm_en) begin
      state_nxt = S_IDLE;
      half_nxt  = '0;
      slot_nxt  = '0;
      spk_nxt   = 1'b0;
      idx_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_TONE;
          half_nxt  = '0;
          slot_nxt  = '0;
          spk_nxt   = 1'b0;
          idx_nxt   = '0;
        end

        S_TONE: begin
          // The slot counter runs on into GAP so the whole slot is timed by
          // one count; any partial half-period is cut off at GAP entry.
          slot_nxt = slot_cnt + SW'(1);
          if (slot_cnt == TONE_LAST) begin
            state_nxt = S_GAP;
            half_nxt  = '0;
            spk_nxt   = 1'b0;
          end else if (half_cnt == hp_last(idx_q)) begin
            half_nxt = '0;
            spk_nxt  = ~spk_q;
          end else begin
            half_nxt = half_cnt + HW'(1);
          end
        end

        S_GAP: begin
          spk_nxt = 1'b0;
          if (slot_cnt == NOTE_LAST) begin
            half_nxt = '0;
            slot_nxt = '0;
            if (idx_q == 3'd7) begin
              state_nxt = S_PAUSE;
            end else begin
              state_nxt = S_TONE;
              idx_nxt   = idx_q + 3'd1;
            end
          end else begin
            slot_nxt = slot_cnt + SW'(1);
          end
        end

        S_PAUSE: begin
          spk_nxt = 1'b0;
          if (slot_cnt == PAUSE_LAST) begin
            state_nxt = S_TONE;
            half_nxt  = '0;
            slot_nxt  = '0;
            idx_nxt   = '0;
          end else begin
            slot_nxt = slot_cnt + SW'(1);
          end
        end

        default: begin
          state_nxt = S_IDLE;
          half_nxt  = '0;
          slot_nxt  = '0;
          spk_nxt   = 1'b0;
          idx_nxt   = '0;
        end
      endcase
    end

    playing_nxt = (state_nxt != S_IDLE);
  end

  // Counter and output registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      half_cnt  <= '0;
      slot_cnt  <= '0;
      spk_q     <= 1'b0;
      idx_q     <= '0;
      playing_q <= 1'b0;
    end else begin
      half_cnt  <= half_nxt;
      slot_cnt  <= slot_nxt;
      spk_q     <= spk_nxt;
      idx_q     <= idx_nxt;
      playing_q <= playing_nxt;
    end
  end

  assign bus.spk_out  = spk_q;
  assign bus.playing  = playing_q;
  assign bus.note_idx = idx_q;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Scoreboard bench for alarm_tone_gen: stimulus pushes expected output
// snapshots keyed by clock-edge number; a monitor compares them on the
// falling edge after that rising edge.
module tb_alarm_tone_gen;

  localparam int unsigned HP [8] = '{100, 89, 79, 74, 66, 59, 52, 49};

  logic clk;
  logic rst_n;

  alarm_tone_if bus ();

  alarm_tone_gen #(
    .CLK_HZ      (104_600),
    .NOTE_CYCLES (1000),
    .GAP_CYCLES  (100),
    .PAUSE_CYCLES(500)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    logic [4:0]  exp;
    int unsigned test;
    int unsigned tag;
  } chk_t;

  chk_t        sb [$];
  chk_t        mon_e;
  int unsigned cyc    = 0;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned tag_n  = 0;
  int unsigned cur_test = 0;
  logic [4:0]  obs;

  assign obs = {bus.playing, bus.note_idx, bus.spk_out};

  // Edge counter: after rising edge N, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input int unsigned test, input int unsigned tag,
                                input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL t%0d#%0d cyc=%0d got play=%b idx=%0d spk=%b want play=%b idx=%0d spk=%b",
                  test, tag, cyc, got[4], got[3:1], got[0], exp[4], exp[3:1], exp[0]);
  endfunction

  function automatic void push(input int unsigned at, input logic play,
                               input logic [2:0] idx, input logic spk);
    chk_t e;
    e.at   = at;
    e.exp  = {play, idx, spk};
    e.test = cur_test;
    e.tag  = tag_n;
    tag_n++;
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation that falls due at this edge.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.at != cyc) begin
        n_chk++;
        $display("FAIL t%0d#%0d missed: due cyc=%0d now cyc=%0d", mon_e.test, mon_e.tag, mon_e.at, cyc);
      end else begin
        check(mon_e.test, mon_e.tag, obs, mon_e.exp);
      end
    end
  end

  task automatic at_cycle(input int unsigned n);
    int unsigned guard = 0;
    while (cyc < n && guard < 30000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      n_chk++;
      $display("FAIL at_cycle reached cyc=%0d want cyc=%0d", cyc, n);
    end
  endtask

  task automatic wait_drain(input int unsigned limit);
    int unsigned guard = 0;
    while (sb.size() != 0 && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain timeout pending=%0d want pending=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int unsigned b, s, base2, d, r, f, g, h;
    rst_n        = 1'b0;
    bus.alarm_en = 1'b0;

    // Reset state.
    cur_test = 0;
    repeat (3) @(negedge clk);
    check(0, 0, obs, 5'b0_000_0);
    rst_n = 1'b1;
    @(negedge clk);
    check(0, 1, obs, 5'b0_000_0);

    // Full pass: tone timing for every note, gaps, pause, restart.
    cur_test = 1;
    b = cyc + 1;
    bus.alarm_en = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      s = b + 1000 * i;
      push(s, 1'b1, 3'(i), 1'b0);
      for (int unsigned k = 1; k * HP[i] < 900; k++) begin
        push(s + k * HP[i] - 1, 1'b1, 3'(i), 1'((k - 1) & 1));
        push(s + k * HP[i],     1'b1, 3'(i), 1'(k & 1));
      end
      push(s + 899, 1'b1, 3'(i), 1'((899 / HP[i]) & 1));
      push(s + 900, 1'b1, 3'(i), 1'b0);
      push(s + 999, 1'b1, 3'(i), 1'b0);
    end
    push(b + 8000, 1'b1, 3'd7, 1'b0);
    push(b + 8250, 1'b1, 3'd7, 1'b0);
    push(b + 8499, 1'b1, 3'd7, 1'b0);
    push(b + 8500, 1'b1, 3'd0, 1'b0);
    push(b + 8599, 1'b1, 3'd0, 1'b0);
    push(b + 8600, 1'b1, 3'd0, 1'b1);
    wait_drain(9000);

    // Disable mid-tone on note 3 while high, then restart from note 0.
    cur_test = 3;
    base2 = b + 8500;
    d = base2 + 3099;
    r = d + 6;
    push(d,     1'b1, 3'd3, 1'b1);
    push(d + 1, 1'b0, 3'd0, 1'b0);
    push(d + 5, 1'b0, 3'd0, 1'b0);
    push(r,       1'b1, 3'd0, 1'b0);
    push(r + 99,  1'b1, 3'd0, 1'b0);
    push(r + 100, 1'b1, 3'd0, 1'b1);
    // Disable landing exactly on the GAP->TONE edge.
    push(r + 999,  1'b1, 3'd0, 1'b0);
    push(r + 1000, 0, 3'd0, 1'b0);
    at_cycle(d);
    bus.alarm_en = 1'b0;
    at_cycle(d + 5);
    bus.alarm_en = 1'b1;
    cur_test = 4;
    at_cycle(r + 999);
    bus.alarm_en = 1'b0;

    // Asynchronous reset mid-PAUSE.
    cur_test = 5;
    at_cycle(r + 1005);
    bus.alarm_en = 1'b1;
    f = r + 1006;
    push(f,        1'b1, 3'd0, 1'b0);
    push(f + 8200, 1'b1, 3'd7, 1'b0);
    at_cycle(f + 8200);
    #2;
    rst_n = 1'b0;
    #1;
    check(5, 100, obs, 5'b0_000_0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    g = cyc + 1;
    push(g,        1'b1, 3'd0, 1'b0);
    push(g + 100,  1'b1, 3'd0, 1'b1);
    push(g + 1150, 1'b1, 3'd1, 1'b1);
    // Asynchronous reset mid-TONE on note 1 while high.
    at_cycle(g + 1150);
    #2;
    rst_n = 1'b0;
    #1;
    check(5, 101, obs, 5'b0_000_0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    h = cyc + 1;
    push(h,       1'b1, 3'd0, 1'b0);
    push(h + 99,  1'b1, 3'd0, 1'b0);
    push(h + 100, 1'b1, 3'd0, 1'b1);
    wait_drain(300);

    bus.alarm_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check(6, 102, obs, 5'b0_000_0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
